unified_mem_arbiter: RTL
========================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory between the core's fetch port (IF) and its
//  load/store port (D). Sits between the ARM core and the one-memory array. Issues at most one
//  access per grant and tracks the outstanding read until its data returns. Flags fetch accesses
//  on mem_is_inst, which drives the InstMem select.
// PARAMETERS
//  READ_LAT      1  cycles from the mem_en cycle to mem_rdata valid; legal range >=1
//  MAX_D_STREAK  4  max consecutive D grants while if_req is pending before IF is forced; >=1
// PORTS
//  clk          in   1   clock; all state updates on the rising edge
//  reset        in   1   synchronous, active-high reset
//  if_req       in   1   fetch request; held with if_addr stable until if_gnt
//  if_addr      in   32  fetch byte address
//  if_gnt       out  1   1-cycle pulse: the fetch is issued to memory this cycle
//  if_rvalid    out  1   1-cycle pulse: if_rdata is valid
//  if_rdata     out  32  fetched instruction
//  d_req        in   1   data request; held with d_we/d_addr/d_wdata stable until d_gnt
//  d_we         in   1   1 = store, 0 = load
//  d_addr       in   32  data byte address
//  d_wdata      in   32  store data
//  d_gnt        out  1   1-cycle pulse: the data access is issued this cycle
//  d_rvalid     out  1   1-cycle pulse: d_rdata is valid (loads only)
//  d_rdata      out  32  load data
//  mem_en       out  1   memory access strobe
//  mem_we       out  1   memory write enable; only meaningful with mem_en
//  mem_is_inst  out  1   1 = the current access is a fetch (InstMem select)
//  mem_addr     out  32  memory address
//  mem_wdata    out  32  memory write data
//  mem_rdata    in   32  read data, valid exactly READ_LAT cycles after the mem_en cycle
//  busy         out  1   high while a read is outstanding (state WAIT)
// BEHAVIOUR
//  - Reset: state=IDLE, lat_cnt=0, d_streak=0, owner=NONE. All outputs are 0 while reset is high.
//  - FSM IDLE/WAIT. Issue slot = any IDLE cycle, or the final WAIT cycle (lat_cnt==1).
//  - Issue is combinational in the slot: the gnt pulse, mem_en=1, and the mem_* fields are driven
//    from the winning port's inputs in the same cycle as the request.
//  - Priority: D wins over IF, except IF wins when if_req=1 and d_streak==MAX_D_STREAK.
//  - d_streak: +1 on each D grant while if_req=1 (saturating). Cleared on an IF grant, or in any
//    cycle with if_req=0.
//  - Store grant: one cycle, no rvalid, state stays or returns to IDLE. The next issue is allowed
//    on the following cycle.
//  - Read grant (load or fetch):
//    - Record owner, set lat_cnt=READ_LAT, enter WAIT.
//    - When lat_cnt==1, assert the owner's rvalid and drive rdata = mem_rdata (combinational).
//    - In that same cycle, evaluate a new issue; if none wins, go to IDLE.
//  - Throughput: one read per READ_LAT cycles, one store per cycle.
//  - mem_is_inst = (issuing port == IF). mem_we = d_we only on a D grant, 0 otherwise.
//  - rvalid goes only to the owner; the other port's rvalid stays 0. Unused rdata outputs hold 0.
//  - Requests arriving during WAIT (before the last cycle) are not granted; they wait.
//  - Simultaneous rvalid and new grant in one cycle is legal and required.
//  - Reset mid-read: the outstanding read is discarded and no rvalid is ever produced for it.
//  - Dropping req before gnt is a protocol violation; the bench asserts against it.
// STRUCTURE
//  - Package arm_mem_pkg:
//    - typedef enum logic {S_IDLE, S_WAIT} arb_state_t
//    - typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} arb_owner_t
//    - localparam DATA_W = 32, ADDR_W = 32
//  - One sub-module, mem_lat_timer: load READ_LAT on a read issue, decrement to 0, expose last=(cnt==1).
//  - Arbitration, streak counter and output muxing stay in the top module.
// TESTING
//  1. Reset held 3 cycles during an outstanding read -> no rvalid afterwards; all outputs 0 during
//     reset.
//  2. Only if_req, if_addr=0x0000_0010, READ_LAT=1
//     -> cycle t: if_gnt=1, mem_is_inst=1, mem_addr=0x10
//     -> cycle t+1: if_rvalid=1, if_rdata=mem_rdata=0xE59F_1004.
//  3. if_req and d_req (load, addr 0x100) in the same cycle
//     -> d_gnt first with mem_is_inst=0; if_gnt in the rvalid cycle of that load.
//  4. d_req store (addr 0x200, wdata 0xDEAD_BEEF) -> 1-cycle d_gnt, mem_we=1, mem_wdata=0xDEADBEEF,
//     no d_rvalid; a queued fetch is granted the next cycle.
//  5. if_req held, 6 back-to-back D loads, MAX_D_STREAK=4 -> grant order D,D,D,D,IF,D,D.
//  6. READ_LAT=3, back-to-back fetches
//     -> if_gnt at t, t+3, t+6; if_rvalid at t+3, t+6; busy high except before t.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types and widths for the unified instruction/data memory arbiter.
// Imported by the arbiter top and its latency timer.
package arm_mem_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/mem_lat_timer.sv
// Read-latency down-counter: loads READ_LAT when a read is issued and counts to zero.
// 'last' marks the cycle in which the memory read data is valid.
module mem_lat_timer #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic last
);

  localparam int unsigned    CNT_W   = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: default assignment first so every path writes cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LAT_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // NOTE: non-blocking assignment for flops so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == ONE);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single unified memory between the fetch (IF) and load/store (D) ports.
// Issues one access per grant, tracks the outstanding read and steers its data back.
module unified_mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_is_inst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned    SW         = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [SW-1:0]  STREAK_ONE = SW'(1);

  arb_state_t    state_q, state_d;
  arb_owner_t    owner_q, owner_d;
  logic [SW-1:0] d_streak_q, d_streak_d;

  logic lat_last;
  logic slot;
  logic win_if;
  logic gnt_if;
  logic gnt_d;
  logic rd_issue;
  logic rv_cycle;

  // Issue slot: any idle cycle, or the cycle the outstanding read data returns.
  assign slot     = !reset && ((state_q == S_IDLE) || lat_last);
  assign rv_cycle = !reset && (state_q == S_WAIT) && lat_last;

  // D has priority unless it has already starved a pending fetch for MAX_D_STREAK grants.
  assign win_if   = if_req && (!d_req || (d_streak_q == STREAK_MAX));
  assign gnt_if   = slot && win_if;
  assign gnt_d    = slot && d_req && !win_if;
  assign rd_issue = gnt_if || (gnt_d && !d_we);

  mem_lat_timer #(
    .READ_LAT (READ_LAT)
  ) u_lat_timer (
    .clk   (clk),
    .reset (reset),
    .load  (rd_issue),
    .last  (lat_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_NONE;
      d_streak_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      d_streak_q <= d_streak_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    d_streak_d = d_streak_q;

    if (rd_issue) begin
      state_d = S_WAIT;
      owner_d = gnt_if ? OWN_IF : OWN_D;
    end else if (rv_cycle) begin
      state_d = S_IDLE;
      owner_d = OWN_NONE;
    end

    if (!if_req || gnt_if) begin
      d_streak_d = '0;
    end else if (gnt_d && (d_streak_q != STREAK_MAX)) begin
      d_streak_d = d_streak_q + STREAK_ONE;
    end
  end

  always_comb begin
    if_gnt      = gnt_if;
    d_gnt       = gnt_d;
    mem_en      = gnt_if || gnt_d;
    mem_we      = gnt_d && d_we;
    mem_is_inst = gnt_if;
    mem_addr    = '0;
    mem_wdata   = '0;
    if_rvalid   = rv_cycle && (owner_q == OWN_IF);
    d_rvalid    = rv_cycle && (owner_q == OWN_D);
    if_rdata    = '0;
    d_rdata     = '0;
    busy        = !reset && (state_q == S_WAIT);

    if (gnt_if) begin
      mem_addr = if_addr;
    end else if (gnt_d) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_wdata = d_wdata;
      end
    end

    if (if_rvalid) begin
      if_rdata = mem_rdata;
    end
    if (d_rvalid) begin
      d_rdata = mem_rdata;
    end
  end

endmodule
